// File: rtl/npu_cluster_scheduler_if.sv
// Control, array and status signals between the AXI-Lite register block,
// the cluster scheduler and the NPU large arrays.
interface npu_cluster_scheduler_if #(
  parameter int NUM_LARGE_ARRAYS = 4,
  parameter int CFG_WIDTH        = 32
);
  logic                            ctrl_start;
  logic                            ctrl_clear;
  logic [NUM_LARGE_ARRAYS-1:0]     cluster_enable;
  logic [NUM_LARGE_ARRAYS*4-1:0]   pe_enable;
  logic [CFG_WIDTH-1:0]            config_reg;
  logic [NUM_LARGE_ARRAYS-1:0]     array_start;
  logic [NUM_LARGE_ARRAYS-1:0]     array_abort;
  logic [NUM_LARGE_ARRAYS*4-1:0]   array_pe_mask;
  logic [CFG_WIDTH-1:0]            array_cfg;
  logic [NUM_LARGE_ARRAYS-1:0]     array_done;
  logic                            status_busy;
  logic                            status_done;
  logic                            status_error;
  logic [1:0]                      err_code;

  modport master (
    output ctrl_start, ctrl_clear, cluster_enable, pe_enable, config_reg, array_done,
    input  array_start, array_abort, array_pe_mask, array_cfg,
    input  status_busy, status_done, status_error, err_code
  );

  modport slave (
    input  ctrl_start, ctrl_clear, cluster_enable, pe_enable, config_reg, array_done,
    output array_start, array_abort, array_pe_mask, array_cfg,
    output status_busy, status_done, status_error, err_code
  );
endinterface

// File: rtl/npu_cluster_scheduler.sv
// Job sequencer: launches large arrays in parallel or one at a time, tracks
// completion under a watchdog and keeps sticky done/error status.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  ST_IDLE   | no job; accepts start/clear, holds sticky status
//  ST_LAUNCH | one cycle: pulse array_start for the arrays being launched
//  ST_WAIT   | waiting for array_done of pending arrays, watchdog running
module npu_cluster_scheduler #(
  parameter int NUM_LARGE_ARRAYS = 4,
  parameter int CFG_WIDTH        = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  npu_cluster_scheduler_if.slave   bus
);
  localparam int N = NUM_LARGE_ARRAYS;

  typedef enum logic [1:0] {ST_IDLE, ST_LAUNCH, ST_WAIT} state_t;

  state_t               state, state_nxt;
  logic [N-1:0]         to_launch, to_launch_nxt;
  logic [N-1:0]         pending, pending_nxt;
  logic [N*4-1:0]       pe_mask_q, pe_mask_nxt;
  logic [CFG_WIDTH-1:0] cfg_q, cfg_nxt;
  logic [15:0]          wdog, wdog_nxt;
  logic                 done_q, done_nxt;
  logic                 err_q, err_nxt;
  logic [1:0]           code_q, code_nxt;
  logic [N-1:0]         start_vec, abort_vec;
  logic [N-1:0]         lowest_bit, launch_vec, pend_left;
  logic [15:0]          timeout;
  logic                 timeout_hit;

  assign timeout     = cfg_q[31:16];
  assign lowest_bit  = to_launch & (~to_launch + {{(N-1){1'b0}}, 1'b1});
  assign launch_vec  = cfg_q[0] ? lowest_bit : to_launch;
  assign pend_left   = pending & ~bus.array_done;
  // 17-bit compare so a saturated watchdog never wraps into a false match
  assign timeout_hit = (timeout != 16'd0) &&
                       (({1'b0, wdog} + 17'd1) == {1'b0, timeout});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      to_launch <= '0;
      pending   <= '0;
      pe_mask_q <= '0;
      cfg_q     <= '0;
      wdog      <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      code_q    <= 2'b00;
    end else begin
      state     <= state_nxt;
      to_launch <= to_launch_nxt;
      pending   <= pending_nxt;
      pe_mask_q <= pe_mask_nxt;
      cfg_q     <= cfg_nxt;
      wdog      <= wdog_nxt;
      done_q    <= done_nxt;
      err_q     <= err_nxt;
      code_q    <= code_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    to_launch_nxt = to_launch;
    pending_nxt   = pending;
    pe_mask_nxt   = pe_mask_q;
    cfg_nxt       = cfg_q;
    wdog_nxt      = wdog;
    done_nxt      = done_q;
    err_nxt       = err_q;
    code_nxt      = code_q;
    start_vec     = '0;
    abort_vec     = '0;

    case (state)
      ST_IDLE: begin
        if (bus.ctrl_clear) begin
          done_nxt = 1'b0;
          err_nxt  = 1'b0;
          code_nxt = 2'b00;
        end else if (bus.ctrl_start) begin
          if (bus.cluster_enable == '0) begin
            done_nxt = 1'b0;
            err_nxt  = 1'b1;
            code_nxt = 2'b01;
          end else begin
            to_launch_nxt = bus.cluster_enable;
            pe_mask_nxt   = bus.pe_enable;
            cfg_nxt       = bus.config_reg;
            done_nxt      = 1'b0;
            err_nxt       = 1'b0;
            code_nxt      = 2'b00;
            state_nxt     = ST_LAUNCH;
          end
        end
      end

      ST_LAUNCH: begin
        start_vec = launch_vec;
        wdog_nxt  = '0;
        if (bus.ctrl_clear) begin
          abort_vec     = pending | launch_vec;
          pending_nxt   = '0;
          to_launch_nxt = '0;
          done_nxt      = 1'b0;
          err_nxt       = 1'b0;
          code_nxt      = 2'b00;
          state_nxt     = ST_IDLE;
        end else begin
          pending_nxt   = pending | launch_vec;
          to_launch_nxt = to_launch & ~launch_vec;
          state_nxt     = ST_WAIT;
        end
      end

      ST_WAIT: begin
        wdog_nxt = (wdog == 16'hFFFF) ? wdog : wdog + 16'd1;
        // Priority: clear, then completion, then timeout
        if (bus.ctrl_clear) begin
          abort_vec     = pending;
          pending_nxt   = '0;
          to_launch_nxt = '0;
          done_nxt      = 1'b0;
          err_nxt       = 1'b0;
          code_nxt      = 2'b00;
          state_nxt     = ST_IDLE;
        end else if (pend_left == '0) begin
          pending_nxt = '0;
          if (to_launch != '0) begin
            state_nxt = ST_LAUNCH;
          end else begin
            done_nxt  = 1'b1;
            state_nxt = ST_IDLE;
          end
        end else if (timeout_hit) begin
          abort_vec     = pend_left;
          pending_nxt   = '0;
          to_launch_nxt = '0;
          err_nxt       = 1'b1;
          code_nxt      = 2'b10;
          state_nxt     = ST_IDLE;
        end else begin
          pending_nxt = pend_left;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  assign bus.array_start   = start_vec;
  assign bus.array_abort   = abort_vec;
  assign bus.array_pe_mask = pe_mask_q;
  assign bus.array_cfg     = cfg_q;
  assign bus.status_busy   = (state != ST_IDLE);
  assign bus.status_done   = done_q;
  assign bus.status_error  = err_q;
  assign bus.err_code      = code_q;
endmodule
